// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of a five-stage ARM pipeline. Owns the program
// counter, fetches 32-bit instructions over a req/ack memory handshake and
// writes the IF/ID pipeline register. Decode stalls hold the stage; branch
// flushes kill the in-flight instruction and redirect the PC.
//
// Ports:
//   clk          pipeline clock, rising edge
//   rst_n        asynchronous active-low reset
//   next_pc      selected next PC from the PC-select mux (PC+4 or target)
//   stall        hazard stall: hold PC and IF/ID
//   flush        branch taken: kill in-flight instruction, redirect to next_pc
//   imem_req     fetch request (registered)
//   imem_addr    fetch address, always the current PC
//   imem_ack     memory returns imem_rdata this cycle
//   imem_rdata   fetched instruction word
//   pc_plus4     PC + 4, combinational, wraps modulo 2^64
//   if_id_pc     PC of the instruction held in IF/ID
//   if_id_instr  instruction held in IF/ID (NOP_INSTR when empty/flushed)
//   if_id_valid  IF/ID holds a real instruction
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [63:0] pc_plus4,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // one cycle after reset, no request
        REQ  = 2'd1,  // request outstanding at pc
        HOLD = 2'd2   // acknowledged word parked while stalled
    } state_e;

    state_e      state_q,       state_d;
    logic [63:0] pc_q,          pc_d;
    logic [63:0] redirect_pc_q, redirect_pc_d;
    logic        drop_q,        drop_d;
    logic [31:0] hold_buf_q,    hold_buf_d;
    logic        req_q,         req_d;
    logic [63:0] if_id_pc_q,    if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc_plus4    = pc_q + 64'd4;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;

    always_comb begin
        // NOTE: every next-state value gets a hold default before any branch,
        // so no path through this block can leave a variable unassigned and
        // infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        drop_d        = drop_q;
        hold_buf_d    = hold_buf_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;

        // Without a stall, a cycle that delivers nothing leaves a bubble.
        // Paths that do deliver an instruction overwrite this below.
        if (!stall) begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end

        if (flush) begin
            // Flush wins over stall and over any returning data.
            if_id_pc_d    = pc_q;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
            case (state_q)
                REQ: begin
                    if (imem_ack) begin
                        pc_d   = next_pc;
                        drop_d = 1'b0;
                    end else begin
                        // The request cannot be withdrawn mid-handshake: keep
                        // it at the old address, remember where to go, and
                        // throw the word away when it finally arrives.
                        redirect_pc_d = next_pc;
                        drop_d        = 1'b1;
                    end
                end
                default: begin
                    // IDLE or HOLD: nothing outstanding, redirect right away.
                    pc_d    = next_pc;
                    state_d = REQ;
                end
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_ack) begin
                        if (drop_q) begin
                            pc_d   = redirect_pc_q;
                            drop_d = 1'b0;
                        end else if (stall) begin
                            hold_buf_d = imem_rdata;
                            state_d    = HOLD;
                        end else begin
                            if_id_pc_d    = pc_q;
                            if_id_instr_d = imem_rdata;
                            if_id_valid_d = 1'b1;
                            pc_d          = next_pc;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = hold_buf_q;
                        if_id_valid_d = 1'b1;
                        pc_d          = next_pc;
                        state_d       = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // The request is a registered copy of "next state is REQ", so it stays
        // glitch-free and constant until the ack.
        req_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            redirect_pc_q <= 64'h0;
            drop_q        <= 1'b0;
            hold_buf_q    <= 32'h0;
            req_q         <= 1'b0;
            if_id_pc_q    <= 64'h0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values, independent of statement order.
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            drop_q        <= drop_d;
            hold_buf_q    <= hold_buf_d;
            req_q         <= req_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Self-checking bench for if_fetch_stage. A transaction-level model (PC,
// a parked-word queue, a pending-redirect queue) predicts the outputs every
// cycle; directed phases pin the model with hand-computed literals, then a
// long randomized phase exercises stall/flush/wait-state/reset combinations.
// ----------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] next_pc = 64'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack   = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [63:0] pc_plus4;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_pc     (next_pc),
        .stall       (stall),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_plus4    (pc_plus4),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0000;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [63:0] m_pc;
    bit          m_started;        // past the post-reset idle cycle
    bit          m_req;
    logic [31:0] m_parked[$];      // word fetched during a stall
    logic [63:0] m_redirect[$];    // target waiting for a killed fetch to return
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;

    task automatic model_reset();
        m_pc      = 64'h0;
        m_started = 1'b0;
        m_req     = 1'b0;
        m_parked.delete();
        m_redirect.delete();
        e_pc      = 64'h0;
        e_instr   = NOP;
        e_valid   = 1'b0;
    endtask

    task automatic bubble_unless_stall();
        if (!stall) begin
            e_instr = NOP;
            e_valid = 1'b0;
        end
    endtask

    task automatic deliver(input logic [31:0] w);
        e_pc    = m_pc;
        e_instr = w;
        e_valid = 1'b1;
        m_pc    = next_pc;
    endtask

    task automatic model_step();
        bit fetched;
        fetched = m_req && imem_ack;
        if (flush) begin
            e_pc    = m_pc;
            e_instr = NOP;
            e_valid = 1'b0;
            if (fetched || !m_started || m_parked.size() != 0) begin
                m_pc = next_pc;
                m_redirect.delete();
            end else begin
                m_redirect.delete();
                m_redirect.push_back(next_pc);
            end
            m_parked.delete();
            m_started = 1'b1;
        end else if (!m_started) begin
            m_started = 1'b1;
            bubble_unless_stall();
        end else if (m_parked.size() != 0) begin
            if (!stall) deliver(m_parked.pop_front());
        end else if (fetched) begin
            if (m_redirect.size() != 0) begin
                m_pc = m_redirect.pop_front();
                bubble_unless_stall();
            end else if (stall) begin
                m_parked.push_back(imem_rdata);
            end else begin
                deliver(imem_rdata);
            end
        end else begin
            bubble_unless_stall();
        end
        m_req = m_started && (m_parked.size() == 0);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Compare process: outputs against model, every cycle, 1 ns after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("model imem_req",    64'(imem_req),    64'(m_req));
            check("model imem_addr",   imem_addr,        m_pc);
            check("model pc_plus4",    pc_plus4,         m_pc + 64'd4);
            check("model if_id_pc",    if_id_pc,         e_pc);
            check("model if_id_instr", 64'(if_id_instr), 64'(e_instr));
            check("model if_id_valid", 64'(if_id_valid), 64'(e_valid));
        end
    end

    // ------------------------------------------------------------------
    // Memory responder and input driver (both act on the falling edge)
    // ------------------------------------------------------------------
    bit          rand_mode    = 1'b0;
    int          mem_wait_dir = 0;
    int          mem_wait_cur = 0;
    int          mem_cnt      = 0;
    bit          dir_stall    = 1'b0;
    bit          dir_flush    = 1'b0;
    logic [63:0] dir_target   = 64'h0;
    logic [63:0] drv_tgt      = 64'h0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                imem_ack = 1'b0;
                mem_cnt  = 0;
            end else if (imem_req) begin
                if (mem_cnt >= (rand_mode ? mem_wait_cur : mem_wait_dir)) begin
                    imem_ack     = 1'b1;
                    imem_rdata   = word_at(imem_addr);
                    mem_cnt      = 0;
                    mem_wait_cur = int'($urandom_range(0, 3));
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = 32'($urandom);
                    mem_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                mem_cnt  = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_mode) begin
                stall   = ($urandom_range(0, 3) == 0);
                flush   = ($urandom_range(0, 7) == 0);
                drv_tgt = {32'($urandom), 32'($urandom) & 32'hFFFF_FFFC};
            end else begin
                stall   = dir_stall;
                flush   = dir_flush;
                drv_tgt = dir_target;
            end
            next_pc = flush ? drv_tgt : m_pc + 64'd4;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed phases followed by randomized traffic
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset imem_req",    64'(imem_req),    64'd0);
        check("reset imem_addr",   imem_addr,        64'h0);
        check("reset if_id_pc",    if_id_pc,         64'h0);
        check("reset if_id_instr", 64'(if_id_instr), 64'(NOP));
        check("reset if_id_valid", 64'(if_id_valid), 64'd0);
        #2 rst_n = 1'b1;

        // Zero-wait sequential fetch.
        cyc();
        check("idle->req imem_req", 64'(imem_req), 64'd1);
        check("idle->req addr",     imem_addr,     64'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("seq if_id_pc",    if_id_pc,         64'(4 * i));
            check("seq if_id_instr", 64'(if_id_instr), 64'(32'h5A5A_0000 | 32'(4 * i)));
            check("seq if_id_valid", 64'(if_id_valid), 64'd1);
        end

        // Two wait states at 0x10 and 0x14.
        mem_wait_dir = 2;
        for (int k = 0; k < 2; k++) begin
            cyc();
            check("wait addr held", imem_addr,        64'h10);
            check("wait bubble v",  64'(if_id_valid), 64'd0);
            check("wait bubble i",  64'(if_id_instr), 64'(NOP));
        end
        cyc();
        check("wait if_id_pc",    if_id_pc,         64'h10);
        check("wait if_id_instr", 64'(if_id_instr), 64'h5A5A_0010);
        check("wait next addr",   imem_addr,        64'h14);
        cyc();
        cyc();
        cyc();
        check("wait2 if_id_pc",   if_id_pc,         64'h14);
        mem_wait_dir = 0;

        // Stall arriving with the ack for 0x20.
        cyc();
        cyc();
        check("pre-stall if_id_pc", if_id_pc, 64'h1C);
        dir_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("hold imem_req",  64'(imem_req),    64'd0);
            check("hold if_id_pc",  if_id_pc,         64'h1C);
            check("hold if_id_val", 64'(if_id_valid), 64'd1);
        end
        dir_stall = 1'b0;
        cyc();
        check("unhold if_id_pc",    if_id_pc,         64'h20);
        check("unhold if_id_instr", 64'(if_id_instr), 64'h5A5A_0020);
        check("unhold next addr",   imem_addr,        64'h24);

        // Flush while the 0x40 request is still waiting.
        for (int k = 0; k < 20; k++) begin
            if (if_id_pc == 64'h3C) break;
            cyc();
        end
        check("reach if_id_pc 0x3C", if_id_pc, 64'h3C);
        mem_wait_dir = 2;
        dir_flush    = 1'b1;
        dir_target   = 64'h100;
        cyc();
        dir_flush = 1'b0;
        check("flush-wait addr kept", imem_addr,        64'h40);
        check("flush-wait if_id_pc",  if_id_pc,         64'h40);
        check("flush-wait instr",     64'(if_id_instr), 64'(NOP));
        check("flush-wait valid",     64'(if_id_valid), 64'd0);
        cyc();
        check("flush-wait addr 2",    imem_addr,        64'h40);
        cyc();
        check("redirect addr",        imem_addr,        64'h100);
        check("discard valid",        64'(if_id_valid), 64'd0);
        mem_wait_dir = 0;
        cyc();
        check("target if_id_pc",      if_id_pc,         64'h100);
        check("target if_id_instr",   64'(if_id_instr), 64'h5A5A_0100);

        // Flush, ack and stall together.
        dir_flush  = 1'b1;
        dir_stall  = 1'b1;
        dir_target = 64'h200;
        cyc();
        dir_stall  = 1'b0;
        check("fas addr",     imem_addr,        64'h200);
        check("fas req",      64'(imem_req),    64'd1);
        check("fas if_id_pc", if_id_pc,         64'h104);
        check("fas valid",    64'(if_id_valid), 64'd0);

        // Park the PC at 0x80 with a long wait, then reset mid-handshake.
        dir_target = 64'h80;
        cyc();
        dir_flush    = 1'b0;
        mem_wait_dir = 5;
        check("pc 0x80", imem_addr, 64'h80);
        cyc();
        #2 rst_n = 1'b0;
        #1;
        check("async rst imem_req", 64'(imem_req),    64'd0);
        check("async rst addr",     imem_addr,        64'h0);
        check("async rst pc_plus4", pc_plus4,         64'h4);
        check("async rst instr",    64'(if_id_instr), 64'(NOP));
        check("async rst valid",    64'(if_id_valid), 64'd0);
        mem_wait_dir = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc();
        check("restart req",  64'(imem_req), 64'd1);
        check("restart addr", imem_addr,     64'h0);
        cyc();
        check("restart if_id_pc", if_id_pc,         64'h0);
        check("restart instr",    64'(if_id_instr), 64'h5A5A_0000);

        // PC at the top of the address space.
        dir_flush  = 1'b1;
        dir_target = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        dir_flush = 1'b0;
        check("top addr",     imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        check("top pc_plus4", pc_plus4,  64'h0);
        cyc();
        check("top if_id_pc", if_id_pc,         64'hFFFF_FFFF_FFFF_FFFC);
        check("top instr",    64'(if_id_instr), 64'h5A5A_0003);
        check("wrap addr",    imem_addr,        64'h0);

        // Randomized traffic with occasional asynchronous resets.
        rand_mode = 1'b1;
        for (int seg = 0; seg < 4; seg++) begin
            repeat (1000) @(posedge clk);
            #3 rst_n = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #3 rst_n = 1'b1;
        end
        repeat (50) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
